// File: rtl/pwm_timer.sv
// pwm_timer: prescaled, period-bounded PWM timebase with a 4-entry register port.
// Optional PWM_SHADOW_EN: compare is double-buffered and loaded only on wrap or clear.
module pwm_timer #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned PRESC_WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [WIDTH-1:0] CounterR,
   output logic [WIDTH-1:0] CompareR,
   output logic             wrap
);

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PERIOD = 2'd1;
   localparam logic [1:0] A_CMP    = 2'd2;
   localparam logic [1:0] A_PRESC  = 2'd3;

   logic                   enable;
   logic [WIDTH-1:0]       period;
   logic [PRESC_WIDTH-1:0] prescale;
   logic [PRESC_WIDTH-1:0] presc_cnt;

   logic wr_ctrl;
   logic wr_period;
   logic wr_cmp;
   logic wr_presc;
   logic clr;
   logic tick;
   logic at_end;
   logic wrap_now;

`ifdef PWM_SHADOW_EN
   logic [WIDTH-1:0] shadow;
`endif

   // write decode and timebase events; clear outranks a same-cycle wrap
   always_comb begin
      wr_ctrl   = we && (addr == A_CTRL);
      wr_period = we && (addr == A_PERIOD);
      wr_cmp    = we && (addr == A_CMP);
      wr_presc  = we && (addr == A_PRESC);
      clr       = wr_ctrl && wdata[1];
      tick      = enable && (presc_cnt == prescale);
      at_end    = CounterR >= period;
      wrap_now  = tick && at_end && !clr;
   end

   // programmable registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable   <= 1'b0;
         period   <= '0;
         prescale <= '0;
      end else begin
         if (wr_ctrl)   enable   <= wdata[0];
         if (wr_period) period   <= wdata;
         if (wr_presc)  prescale <= wdata[PRESC_WIDTH-1:0];
      end
   end

   // prescaler: reloads on match, frozen while disabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_cnt <= '0;
      end else if (clr || tick) begin
         presc_cnt <= '0;
      end else if (enable) begin
         presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
      end
   end

   // period counter and wrap pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         CounterR <= '0;
         wrap     <= 1'b0;
      end else begin
         wrap <= wrap_now;
         if (clr) begin
            CounterR <= '0;
         end else if (tick) begin
            CounterR <= at_end ? '0 : CounterR + WIDTH'(1);
         end
      end
   end

`ifdef PWM_SHADOW_EN
   // active compare takes the pre-write shadow value on wrap or clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow   <= '0;
         CompareR <= '0;
      end else begin
         if (wr_cmp) shadow <= wdata;
         if (clr || wrap_now) CompareR <= shadow;
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         CompareR <= '0;
      end else if (wr_cmp) begin
         CompareR <= wdata;
      end
   end
`endif

   always_comb begin
      rdata = '0;
      case (addr)
         A_CTRL:   rdata = WIDTH'(enable);
         A_PERIOD: rdata = period;
`ifdef PWM_SHADOW_EN
         A_CMP:    rdata = shadow;
`else
         A_CMP:    rdata = CompareR;
`endif
         default:  rdata = WIDTH'(prescale);
      endcase
   end

endmodule

// File: tb/tb_pwm_timer.sv
// Randomized scoreboard bench for pwm_timer against an arithmetic reference model.
module tb_pwm_timer;

   localparam int unsigned WIDTH       = 8;
   localparam int unsigned PRESC_WIDTH = 8;
   localparam int          PMOD        = 1 << PRESC_WIDTH;

   logic             clk;
   logic             reset;
   logic             we;
   logic [1:0]       addr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;
   logic [WIDTH-1:0] CounterR;
   logic [WIDTH-1:0] CompareR;
   logic             wrap;

   pwm_timer #(.WIDTH(WIDTH), .PRESC_WIDTH(PRESC_WIDTH)) dut (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .CounterR(CounterR), .CompareR(CompareR), .wrap(wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      int cmp;
      int wrp;
      int rd;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // reference state
   int m_en, m_per, m_ps, m_pc, m_cnt, m_cmp, m_sh, m_wrap;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_en = 0; m_per = 0; m_ps = 0; m_pc = 0;
      m_cnt = 0; m_cmp = 0; m_sh = 0; m_wrap = 0;
   endfunction

   function automatic int exp_rd(input int a);
      case (a)
         0: return m_en;
         1: return m_per;
`ifdef PWM_SHADOW_EN
         2: return m_sh;
`else
         2: return m_cmp;
`endif
         default: return m_ps;
      endcase
   endfunction

   // true when the coming edge would both tick and wrap
   function automatic bit wrap_next();
      return (m_en != 0) && (m_pc == m_ps) && (m_cnt >= m_per);
   endfunction

   function automatic void model_step(input bit w, input int a, input int d);
      bit tick, fin, clr;
      int n_pc, n_cnt, n_cmp, n_wrap;
      tick   = (m_en != 0) && (m_pc == m_ps);
      fin    = m_cnt >= m_per;
      clr    = w && (a == 0) && (((d >> 1) & 1) == 1);
      n_pc   = m_pc;
      n_cnt  = m_cnt;
      n_cmp  = m_cmp;
      n_wrap = 0;
      if (clr) begin
         n_pc  = 0;
         n_cnt = 0;
`ifdef PWM_SHADOW_EN
         n_cmp = m_sh;
`endif
      end else if (m_en != 0) begin
         n_pc = tick ? 0 : (m_pc + 1) % PMOD;
         if (tick) begin
            if (fin) begin
               n_cnt  = 0;
               n_wrap = 1;
`ifdef PWM_SHADOW_EN
               n_cmp  = m_sh;
`endif
            end else begin
               n_cnt = m_cnt + 1;
            end
         end
      end
      if (w) begin
         case (a)
            0: m_en  = d & 1;
            1: m_per = d;
`ifdef PWM_SHADOW_EN
            2: m_sh  = d;
`else
            2: n_cmp = d;
`endif
            default: m_ps = d % PMOD;
         endcase
      end
      m_pc = n_pc; m_cnt = n_cnt; m_cmp = n_cmp; m_wrap = n_wrap;
   endfunction

   // one bus cycle: drive after negedge, update model at posedge, queue expectation
   task automatic cycle(input bit w, input logic [1:0] a, input logic [WIDTH-1:0] d);
      exp_t e;
      @(negedge clk);
      #1;
      we = w; addr = a; wdata = d;
      @(posedge clk);
      model_step(w, int'(a), int'(d));
      e.cnt = m_cnt; e.cmp = m_cmp; e.wrp = m_wrap; e.rd = exp_rd(int'(a));
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
   endtask

   // kind 0: until a wrap is due; kind 1: until counter equals val
   task automatic wait_state(input int kind, input int val, input string name);
      for (int i = 0; i < 600; i++) begin
         if (kind == 0 && wrap_next()) return;
         if (kind == 1 && m_cnt == val) return;
         idle(1);
      end
      vectors++;
      miscompares++;
      $display("FAIL %s: wait expired, got timeout, expected condition", name);
   endtask

   // monitor: every sampled cycle is compared against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("CounterR", int'(CounterR), e.cnt);
            chk("CompareR", int'(CompareR), e.cmp);
            chk("wrap",     int'(wrap),     e.wrp);
            chk("rdata",    int'(rdata),    e.rd);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_CounterR"}, int'(CounterR), 0);
      chk({tag, "_CompareR"}, int'(CompareR), 0);
      chk({tag, "_wrap"},     int'(wrap),     0);
      chk({tag, "_rdata0"},   int'(rdata),    0);
   endtask

   initial begin
      logic [WIDTH-1:0] d;
      logic [1:0]       a;
      model_reset();
      reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = '0;
      #1 reset = 1'b0;
      #1 check_reset_outputs("por");
      @(negedge clk);
      #1 reset = 1'b1;
      idle(3);

      // basic count: PERIOD 3, PRESCALE 0, COMPARE 2
      cycle(1'b1, 2'd1, 8'd3);
      cycle(1'b1, 2'd3, 8'd0);
      cycle(1'b1, 2'd2, 8'd2);
      cycle(1'b1, 2'd0, 8'd1);
      idle(12);

      // compare write coinciding with a wrap
      wait_state(0, 0, "wait_wrap_cmp");
      cycle(1'b1, 2'd2, 8'd7);
      idle(10);

      // prescaler
      cycle(1'b1, 2'd3, 8'd2);
      cycle(1'b1, 2'd1, 8'd1);
      idle(20);

      // period shrink below the running count
      cycle(1'b1, 2'd3, 8'd0);
      cycle(1'b1, 2'd1, 8'd20);
      wait_state(1, 10, "wait_cnt10");
      cycle(1'b1, 2'd1, 8'd4);
      idle(6);

      // clear on the same edge as a tick-and-wrap
      cycle(1'b1, 2'd1, 8'd3);
      wait_state(0, 0, "wait_wrap_clr");
      cycle(1'b1, 2'd0, 8'd3);
      idle(6);

      // asynchronous reset mid-count
      cycle(1'b1, 2'd1, 8'd10);
      wait_state(1, 5, "wait_cnt5");
      @(negedge clk);
      #1;
      we = 1'b0; addr = 2'd0; reset = 1'b0;
      #1 check_reset_outputs("midrst");
      model_reset();
      @(negedge clk);
      #1 reset = 1'b1;
      idle(5);

      // randomized traffic
      cycle(1'b1, 2'd0, 8'd1);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 75) begin
            idle(1);
         end else begin
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            case (a)
               2'd0: begin
                  d[0] = ($urandom_range(0, 9) != 0);
                  d[1] = ($urandom_range(0, 7) == 0);
               end
               2'd1: if ($urandom_range(0, 9) != 0) d = 8'($urandom_range(0, 12));
               2'd3: if ($urandom_range(0, 19) != 0) d = 8'($urandom_range(0, 3));
               default: ;
            endcase
            cycle(1'b1, a, d);
         end
      end

      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pwm_timer.md
# pwm_timer

Memory-mapped PWM timebase that produces the `CounterR` and `CompareR` values consumed by the downstream LED comparator stage (`LED = CompareR >= CounterR`). The block contains:

- a prescaler;
- a period-bounded up-counter;
- a double-buffered compare register.

All are programmed by the MIPS core through a small register port. It sits between the processor's data-memory bus and the PWM output stage.

## Interface
Parameters:
- `WIDTH`, 8, width of counter, period, compare and bus data.
- `PRESC_WIDTH`, 8, width of prescaler register and prescaler counter; must be ≤ `WIDTH`.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `we`  input  1  register write strobe, sampled on `clk`.
- `addr`  input  2  register select: 0 CTRL, 1 PERIOD, 2 COMPARE, 3 PRESCALE.
- `wdata`  input  `WIDTH`  write data.
- `rdata`  output  `WIDTH`  combinational readback of the register selected by `addr`.
- `CounterR`  output  `WIDTH`  current counter value, to the comparator stage.
- `CompareR`  output  `WIDTH`  active compare value, to the comparator stage.
- `wrap`  output  1  one-cycle pulse on each period wrap.

## Operation
- **Reset** (`reset` = 0, asynchronous) clears the following to 0: CTRL.enable, PERIOD, shadow compare, PRESCALE, prescaler counter, `CounterR`, `CompareR` and `wrap`.
- **CTRL write**:
  - `wdata[0]` sets `enable`.
  - `wdata[1]` = 1 requests a clear. The clear is self-clearing and is never stored.
  - Other bits are ignored.
- **Readback**:
  - addr 0: `{0…, enable}`
  - addr 1: PERIOD
  - addr 2: shadow compare
  - addr 3: PRESCALE, zero-extended
- **Prescaler**:
  - While `enable` = 1, the prescaler counter increments each cycle.
  - When the prescaler counter == PRESCALE, it reloads to 0 and asserts an internal `tick`.
  - PRESCALE = 0 gives a tick every cycle.
- **Counter**, on `tick`:
  - If `CounterR` >= PERIOD: `CounterR` ← 0, `CompareR` ← shadow compare, and `wrap` = 1 for the next cycle.
  - Otherwise: `CounterR` ← `CounterR` + 1.
- **Disabled** (`enable` = 0): prescaler, `CounterR` and `CompareR` hold their values, and `wrap` = 0.
- **Clear**: the prescaler counter and `CounterR` go to 0 and `CompareR` ← shadow compare, with no `wrap` pulse. Clear has priority over `tick` in the same cycle and takes effect regardless of `enable`.
- **Arithmetic**: all arithmetic is unsigned at `WIDTH` bits. The `>=` wrap test means that lowering PERIOD below the current `CounterR` forces a wrap on the next tick. There is no rollover past PERIOD.

## Timing
- A register write is visible on `rdata` in the cycle after the `we` edge.
- A write to PERIOD or PRESCALE affects the very next tick/wrap decision.
- **Simultaneous write and wrap**:
  - With a COMPARE write in the same cycle as a wrap, `CompareR` loads the *old* shadow value. The new value takes effect at the following wrap.
  - With a PERIOD write in the same cycle as a wrap, the wrap test uses the old PERIOD.
- **Period length**:
  - With PRESCALE = P and PERIOD = N, the period is (N+1)·(P+1) cycles.
  - `wrap` is high for exactly 1 cycle per period, in the cycle after `CounterR` returns to 0.
- **Reset mid-operation**: all outputs go to 0 immediately (asynchronously). Counting resumes only after a CTRL write sets `enable`.
- `rdata` has zero latency (combinational from `addr` and the register state).

## Configuration
- `PWM_SHADOW_EN` defined:
  - COMPARE writes go to the shadow register.
  - `CompareR` updates only on wrap or clear, so there are no glitched PWM periods.
- `PWM_SHADOW_EN` undefined:
  - No shadow register exists.
  - A COMPARE write updates `CompareR` on the write edge.
  - Wrap and clear do not touch `CompareR`.
  - Readback at addr 2 returns `CompareR`.

## Test plan
- **Reset**: assert `reset` = 0 mid-count with `CounterR` = 5 → `CounterR`, `CompareR`, `wrap` and `rdata`@addr0 all read 0 immediately. After release with no writes, `CounterR` stays 0.
- **Basic count**: PERIOD = 3, PRESCALE = 0, COMPARE = 2, enable → `CounterR` sequence 0,1,2,3,0,… Each `wrap` pulse is 1 cycle wide, in the cycle after the 3→0 transition. `CompareR` = 2 after the first wrap.
- **Prescaler**: PRESCALE = 2, PERIOD = 1 → `CounterR` changes every 3 cycles, and the `wrap` interval is 6 cycles.
- **Shadow**, with `PWM_SHADOW_EN`: while `CompareR` = 2, write COMPARE = 7 in the same cycle as a wrap → `CompareR` stays 2 for that period and becomes 7 at the next wrap. Without the macro, `CompareR` = 7 one cycle after the write.
- **Period shrink**: `CounterR` = 10, write PERIOD = 4 → `CounterR` goes to 0 on the next tick and `wrap` pulses once.
- **Clear vs tick**: CTRL write of 0x3 on a cycle where `tick` and a wrap would coincide → `CounterR` = 0 and no `wrap` pulse. Counting continues 1,2,… afterwards.
